// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: sequential advance, stall hold, EX-stage redirect with a
// timed flush of the younger stages, and a sticky trap on misaligned targets.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0040_0000,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic        branch_or_jalr_i,
   input  logic [31:0] ex_pc_i,
   input  logic [31:0] ex_imm_i,
   input  logic [31:0] ex_rs1_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        flush_o,
   output logic        trap_o,
   output logic [31:0] trap_pc_o,
   output logic [31:0] redirect_count_o,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_TRAP     = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

   state_t      state_q, state_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;
   logic [31:0] pc_d, trap_pc_d, count_d;
   logic        flush_d, trap_d;
   logic [31:0] target;
   logic        misaligned;

   // branch_taken_i is a level sampled on every rising edge; there is no
   // handshake back to EX, a request outside ST_RUN is simply dropped.
   assign target     = branch_or_jalr_i ? (ex_pc_i + ex_imm_i)
                                        : ((ex_rs1_i + ex_imm_i) & ~32'h1);
   assign misaligned = target[1];
   assign pc_plus4_o = pc_o + 32'd4;
   assign state_o    = state_q;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      pc_d        = pc_o;
      trap_pc_d   = trap_pc_o;
      count_d     = redirect_count_o;
      flush_d     = flush_o;
      trap_d      = trap_o;
      case (state_q)
         ST_RUN: begin
            if (branch_taken_i) begin
               if (!misaligned) begin
                  pc_d        = target;
                  state_d     = ST_REDIRECT;
                  flush_cnt_d = FLUSH_INIT;
                  count_d     = redirect_count_o + 32'd1;
                  flush_d     = 1'b1;
               end else begin
                  state_d   = ST_TRAP;
                  trap_pc_d = ex_pc_i;
                  trap_d    = 1'b1;
                  flush_d   = 1'b1;
               end
            end else if (!stall_i) begin
               pc_d = pc_plus4_o;
            end
         end
         ST_REDIRECT: begin
            if (!stall_i) pc_d = pc_plus4_o;
            // Counter runs independent of stall so flush length is fixed.
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q <= 3'd1) begin
               state_d = ST_RUN;
               flush_d = 1'b0;
            end
         end
         ST_TRAP: begin
            flush_d = 1'b1;
            trap_d  = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_RUN;
         flush_cnt_q      <= 3'd0;
         pc_o             <= RESET_PC;
         trap_pc_o        <= 32'd0;
         redirect_count_o <= 32'd0;
         flush_o          <= 1'b0;
         trap_o           <= 1'b0;
      end else begin
         state_q          <= state_d;
         flush_cnt_q      <= flush_cnt_d;
         pc_o             <= pc_d;
         trap_pc_o        <= trap_pc_d;
         redirect_count_o <= count_d;
         flush_o          <= flush_d;
         trap_o           <= trap_d;
      end
   end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: the driver queues the expected post-edge
// outputs for each cycle and a negedge monitor pops and compares them.
module tb_pc_redirect_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic        flush;
      logic        trap;
      logic [31:0] trap_pc;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_i = 1'b0;
   logic        branch_taken_i = 1'b0;
   logic        branch_or_jalr_i = 1'b1;
   logic [31:0] ex_pc_i = 32'd0;
   logic [31:0] ex_imm_i = 32'd0;
   logic [31:0] ex_rs1_i = 32'd0;
   logic [31:0] pc_o, pc_plus4_o, trap_pc_o, redirect_count_o;
   logic        flush_o, trap_o;
   logic [1:0]  state_o;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_err = 0;

   pc_redirect_unit #(.RESET_PC(32'h0040_0000), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
      .branch_or_jalr_i(branch_or_jalr_i), .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i),
      .ex_rs1_i(ex_rs1_i), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .flush_o(flush_o),
      .trap_o(trap_o), .trap_pc_o(trap_pc_o), .redirect_count_o(redirect_count_o),
      .state_o(state_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(logic [31:0] pc, logic fl, logic tr, logic [31:0] tpc, logic [31:0] cnt);
      exp_t e;
      e.pc = pc; e.flush = fl; e.trap = tr; e.trap_pc = tpc; e.cnt = cnt;
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all(string nm, exp_t e);
      chk({nm, ".pc"}, pc_o, e.pc);
      chk({nm, ".pc_plus4"}, pc_plus4_o, e.pc + 32'd4);
      chk({nm, ".flush"}, {31'd0, flush_o}, {31'd0, e.flush});
      chk({nm, ".trap"}, {31'd0, trap_o}, {31'd0, e.trap});
      chk({nm, ".trap_pc"}, trap_pc_o, e.trap_pc);
      chk({nm, ".count"}, redirect_count_o, e.cnt);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() != 0) check_all(name_q.pop_front(), exp_q.pop_front());
   end

   // driver: apply inputs for one cycle, queue the expected post-edge outputs
   task automatic cycle(string nm, logic st, logic tk, logic bj,
                        logic [31:0] epc, logic [31:0] imm, logic [31:0] rs1, exp_t e);
      stall_i = st; branch_taken_i = tk; branch_or_jalr_i = bj;
      ex_pc_i = epc; ex_imm_i = imm; ex_rs1_i = rs1;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
   endtask

   task automatic idle(string nm, logic st, exp_t e);
      cycle(nm, st, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, e);
   endtask

   initial begin
      // power-on reset
      #1 reset = 1'b0;
      #2 check_all("por", mk(32'h0040_0000, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b1;
      #1 chk("release.pc", pc_o, 32'h0040_0000);

      // sequential fetch
      idle("seq1", 0, mk(32'h0040_0004, 0, 0, 0, 0));
      idle("seq2", 0, mk(32'h0040_0008, 0, 0, 0, 0));
      idle("seq3", 0, mk(32'h0040_000C, 0, 0, 0, 0));
      idle("seq4", 0, mk(32'h0040_0010, 0, 0, 0, 0));

      // taken branch backwards, requests during the flush are dropped
      cycle("br", 0, 1, 1, 32'h0040_0010, 32'hFFFF_FFF8, 32'h0, mk(32'h0040_0008, 1, 0, 0, 1));
      cycle("br_ign1", 0, 1, 1, 32'h0040_0100, 32'h0, 32'h0, mk(32'h0040_000C, 1, 0, 0, 1));
      cycle("br_ign2", 0, 1, 1, 32'h0040_0100, 32'h0, 32'h0, mk(32'h0040_0010, 0, 0, 0, 1));
      idle("br_run", 0, mk(32'h0040_0014, 0, 0, 0, 1));

      // jalr clears bit 0
      cycle("jalr", 0, 1, 0, 32'h0, 32'h4, 32'h0040_0101, mk(32'h0040_0104, 1, 0, 0, 2));
      idle("jalr_f", 0, mk(32'h0040_0108, 1, 0, 0, 2));
      idle("jalr_run", 0, mk(32'h0040_010C, 0, 0, 0, 2));

      // redirect wins over stall, flush still times out under stall
      cycle("stall_br", 1, 1, 1, 32'h0040_0100, 32'h100, 32'h0, mk(32'h0040_0200, 1, 0, 0, 3));
      idle("stall_f", 1, mk(32'h0040_0200, 1, 0, 0, 3));
      idle("stall_run", 1, mk(32'h0040_0200, 0, 0, 0, 3));
      idle("stall_hold", 1, mk(32'h0040_0200, 0, 0, 0, 3));
      idle("unstall", 0, mk(32'h0040_0204, 0, 0, 0, 3));

      // counter wrap
      #2 force dut.redirect_count_o = 32'hFFFF_FFFF;
      #1 release dut.redirect_count_o;
      cycle("wrap", 0, 1, 1, 32'h0040_0300, 32'h10, 32'h0, mk(32'h0040_0310, 1, 0, 0, 0));
      idle("wrap_f", 0, mk(32'h0040_0314, 1, 0, 0, 0));
      idle("wrap_run", 0, mk(32'h0040_0318, 0, 0, 0, 0));

      // misaligned target traps; everything frozen until reset
      cycle("trap", 0, 1, 1, 32'h0040_0020, 32'h6, 32'h0, mk(32'h0040_0318, 1, 1, 32'h0040_0020, 0));
      cycle("trap_br", 0, 1, 1, 32'h0040_0500, 32'h0, 32'h0, mk(32'h0040_0318, 1, 1, 32'h0040_0020, 0));
      idle("trap_hold", 0, mk(32'h0040_0318, 1, 1, 32'h0040_0020, 0));
      #2 reset = 1'b0;
      #1 check_all("trap_rst", mk(32'h0040_0000, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b1;
      idle("trap_exit", 0, mk(32'h0040_0004, 0, 0, 0, 0));

      // async reset in the middle of a redirect flush
      cycle("mid_br", 0, 1, 1, 32'h0040_0040, 32'h20, 32'h0, mk(32'h0040_0060, 1, 0, 0, 1));
      #2 reset = 1'b0;
      #1 check_all("mid_rst", mk(32'h0040_0000, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b1;
      idle("mid_exit1", 0, mk(32'h0040_0004, 0, 0, 0, 0));
      idle("mid_exit2", 0, mk(32'h0040_0008, 0, 0, 0, 0));

      // drain and report
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
